// File: rtl/wash_panel_pkg.sv
// Shared types and constants for the washer front-panel controller.
package wash_panel_pkg;

  // Panel controller states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_WAIT_SOAP = 3'd2,
    ST_LAUNCH    = 3'd3,
    ST_RUNNING   = 3'd4,
    ST_DONE      = 3'd5
  } panel_state_e;

  // Program indices as understood by the washer FSM.
  localparam logic [2:0] COLD_WASH = 3'd0;
  localparam logic [2:0] HOT_WASH  = 3'd1;
  localparam logic [2:0] RINSE_DRY = 3'd2;
  localparam logic [2:0] ONLY_DRY  = 3'd3;

  // Bit i set = program i needs soap (the two wash programs).
  localparam logic [7:0] DEFAULT_SOAP_PROG_MASK = 8'b0000_0011;

  // Soap requirement lookup for a program index.
  function automatic logic soap_required(input logic [7:0] mask, input logic [2:0] prog);
    return mask[prog];
  endfunction

  // Two-digit BCD of a binary value; anything from 99 upward shows as 99.
  function automatic logic [7:0] bin_to_bcd2(input logic [7:0] bin);
    logic [7:0] tens;
    logic [7:0] ones;
    if (bin >= 8'd99) begin
      return 8'h99;
    end else begin
      tens = bin / 8'd10;
      ones = bin - (tens * 8'd10);
      return {tens[3:0], ones[3:0]};
    end
  endfunction

endpackage

// File: rtl/panel_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter, rising-edge press pulse.
// A stable raw edge produces the press pulse 2 + DEBOUNCE_CYCLES cycles later.
module panel_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic             press_q;
  logic             press_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive samples that disagree with the settled level; flip when enough.
  always_comb begin
    level_d = level_q;
    cnt_d   = {CNT_W{1'b0}};
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        cnt_d   = {CNT_W{1'b0}};
        press_d = sync2_q;
      end else begin
        level_d = level_q;
        cnt_d   = cnt_q + CNT_W'(1);
        press_d = 1'b0;
      end
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // Settled level, counter and press pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      press_q <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/wash_panel_ctrl.sv
// Washer front-panel controller: debounced buttons, program selection, start
// preconditions (door, soap), run tracking and panel display/LEDs.
// Optional macro PANEL_BCD_EN: display shows two BCD digits instead of binary.
module wash_panel_ctrl
  import wash_panel_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = 4,
  parameter int         NUM_PROGRAMS    = 4,
  parameter int         DONE_HOLD       = 16,
  parameter logic [7:0] SOAP_PROG_MASK  = DEFAULT_SOAP_PROG_MASK
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_prog_raw,
  input  logic       btn_start_raw,
  input  logic       btn_cancel_raw,
  input  logic       door_closed,
  input  logic       soap_present,
  input  logic       program_done,
  input  logic [7:0] timer_display,
  output logic [2:0] program_selection,
  output logic       start,
  output logic       washer_abort,
  output logic       busy,
  output logic       soap_warning_led,
  output logic       door_alarm,
  output logic       done_led,
  output logic [7:0] disp_value
);

  localparam logic [2:0] SEL_LAST = 3'(NUM_PROGRAMS - 1);
  localparam int HOLD_W = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DONE_HOLD - 1);

  logic              prog_press_s;
  logic              start_press_s;
  logic              cancel_press_s;
  logic              any_press_s;
  logic [7:0]        disp_src_s;

  panel_state_e      state_q;
  panel_state_e      state_d;
  logic [2:0]        sel_q;
  logic [2:0]        sel_d;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic [HOLD_W-1:0] hold_cnt_d;
  logic              door_latch_q;
  logic              door_latch_d;
  logic              start_q;
  logic              start_d;
  logic              abort_q;
  logic              abort_d;
  logic              busy_q;
  logic              busy_d;
  logic              soap_led_q;
  logic              soap_led_d;
  logic              done_led_q;
  logic              done_led_d;
  logic [2:0]        prog_sel_q;
  logic [2:0]        prog_sel_d;
  logic [7:0]        disp_q;
  logic [7:0]        disp_d;

  panel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prog (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_prog_raw),
    .press (prog_press_s)
  );

  panel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_start_raw),
    .press (start_press_s)
  );

  panel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_cancel (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_cancel_raw),
    .press (cancel_press_s)
  );

  assign any_press_s = prog_press_s | start_press_s | cancel_press_s;

  // Next-state logic; presses not consumed by the current state are simply dropped.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    hold_cnt_d   = {HOLD_W{1'b0}};
    abort_d      = 1'b0;
    // Any press acknowledges a door alarm latched by a failed start attempt.
    if (any_press_s) begin
      door_latch_d = 1'b0;
    end else begin
      door_latch_d = door_latch_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (prog_press_s) begin
          if (sel_q == SEL_LAST) begin
            sel_d = COLD_WASH;
          end else begin
            sel_d = sel_q + 3'd1;
          end
        end else begin
          sel_d = sel_q;
        end
        if (start_press_s) begin
          state_d = ST_ARM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (!door_closed) begin
          state_d      = ST_IDLE;
          door_latch_d = 1'b1;
        end else if (soap_required(SOAP_PROG_MASK, sel_q) && !soap_present) begin
          state_d = ST_WAIT_SOAP;
        end else begin
          state_d = ST_LAUNCH;
        end
      end
      ST_WAIT_SOAP: begin
        if (soap_present) begin
          state_d = ST_LAUNCH;
        end else if (cancel_press_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_SOAP;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_RUNNING;
      end
      ST_RUNNING: begin
        // Cancel outranks a simultaneous program_done so the washer is always aborted.
        if (cancel_press_s) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
        end else if (program_done) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUNNING;
        end
      end
      ST_DONE: begin
        if (any_press_s) begin
          state_d = ST_IDLE;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = ST_IDLE;
        end else begin
          state_d    = ST_DONE;
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output values decoded from the state being entered, so they line up with it.
  always_comb begin
    start_d    = (state_d == ST_LAUNCH);
    busy_d     = (state_d == ST_LAUNCH) || (state_d == ST_RUNNING);
    soap_led_d = (state_d == ST_WAIT_SOAP);
    done_led_d = (state_d == ST_DONE);
    // Selection is presented at launch and then frozen for the whole run.
    if (state_d == ST_LAUNCH) begin
      prog_sel_d = sel_q;
    end else begin
      prog_sel_d = prog_sel_q;
    end
    case (state_d)
      ST_RUNNING: disp_src_s = timer_display;
      ST_DONE:    disp_src_s = 8'd0;
      default:    disp_src_s = {5'd0, sel_d};
    endcase
`ifdef PANEL_BCD_EN
    disp_d = bin_to_bcd2(disp_src_s);
`else
    disp_d = disp_src_s;
`endif
  end

  // Controller state, selection, done-hold counter and door-alarm latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sel_q        <= COLD_WASH;
      hold_cnt_q   <= {HOLD_W{1'b0}};
      door_latch_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      hold_cnt_q   <= hold_cnt_d;
      door_latch_q <= door_latch_d;
    end
  end

  // Registered panel and washer-interface outputs; reset clears them at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q    <= 1'b0;
      abort_q    <= 1'b0;
      busy_q     <= 1'b0;
      soap_led_q <= 1'b0;
      done_led_q <= 1'b0;
      prog_sel_q <= 3'd0;
      disp_q     <= 8'd0;
    end else begin
      start_q    <= start_d;
      abort_q    <= abort_d;
      busy_q     <= busy_d;
      soap_led_q <= soap_led_d;
      done_led_q <= done_led_d;
      prog_sel_q <= prog_sel_d;
      disp_q     <= disp_d;
    end
  end

  assign start             = start_q;
  assign washer_abort      = abort_q;
  assign busy              = busy_q;
  assign soap_warning_led  = soap_led_q;
  assign done_led          = done_led_q;
  assign program_selection = prog_sel_q;
  assign disp_value        = disp_q;
  // An open door during a run alarms immediately, not a cycle later.
  assign door_alarm        = door_latch_q | ((state_q == ST_RUNNING) & ~door_closed);

endmodule

// File: tb/tb_wash_panel_ctrl.sv
// Self-checking bench for wash_panel_ctrl: directed scenarios followed by random
// panel operations, checked against a transaction-level model of the panel.
module tb_wash_panel_ctrl;
  import wash_panel_pkg::*;

  localparam int NPROG = 4;
  localparam int DHOLD = 16;
  localparam int M_IDLE = 0;
  localparam int M_WAIT = 1;
  localparam int M_RUN  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_prog_raw = 1'b0;
  logic       btn_start_raw = 1'b0;
  logic       btn_cancel_raw = 1'b0;
  logic       door_closed = 1'b1;
  logic       soap_present = 1'b1;
  logic       program_done = 1'b0;
  logic [7:0] timer_display = 8'd0;
  logic [2:0] program_selection;
  logic       start;
  logic       washer_abort;
  logic       busy;
  logic       soap_warning_led;
  logic       door_alarm;
  logic       done_led;
  logic [7:0] disp_value;

  int checks = 0;
  int failures = 0;
  int start_seen = 0;
  int abort_seen = 0;
  int done_seen = 0;

  // Model of what the user should see.
  int m_state = M_IDLE;
  int m_sel = 0;
  int m_latch = 0;
  int m_starts = 0;
  int m_aborts = 0;
  int m_launch_sel = 0;

  always #5 clk = ~clk;

  wash_panel_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .btn_prog_raw      (btn_prog_raw),
    .btn_start_raw     (btn_start_raw),
    .btn_cancel_raw    (btn_cancel_raw),
    .door_closed       (door_closed),
    .soap_present      (soap_present),
    .program_done      (program_done),
    .timer_display     (timer_display),
    .program_selection (program_selection),
    .start             (start),
    .washer_abort      (washer_abort),
    .busy              (busy),
    .soap_warning_led  (soap_warning_led),
    .door_alarm        (door_alarm),
    .done_led          (done_led),
    .disp_value        (disp_value)
  );

  // Count cycles each pulse/LED output is high, sampled just after the clock edge.
  always @(posedge clk) begin
    #2;
    if (start === 1'b1) start_seen++;
    if (washer_abort === 1'b1) abort_seen++;
    if (done_led === 1'b1) done_seen++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_disp(input int v);
`ifdef PANEL_BCD_EN
    if (v >= 99) return 8'h99;
    return 8'(((v / 10) * 16) + (v % 10));
`else
    return 8'(v);
`endif
  endfunction

  task automatic check_all(input string tag);
    int run;
    run = (m_state == M_RUN) ? 1 : 0;
    check_eq({tag, "/busy"}, 32'(busy), 32'(run));
    check_eq({tag, "/soap_led"}, 32'(soap_warning_led), 32'((m_state == M_WAIT) ? 1 : 0));
    check_eq({tag, "/done_led"}, 32'(done_led), 32'd0);
    check_eq({tag, "/disp"}, 32'(disp_value),
             32'(exp_disp(run != 0 ? int'(timer_display) : m_sel)));
    check_eq({tag, "/door_alarm"}, 32'(door_alarm),
             32'(((m_latch != 0) || (run != 0 && !door_closed)) ? 1 : 0));
    check_eq({tag, "/starts"}, 32'(start_seen), 32'(m_starts));
    check_eq({tag, "/aborts"}, 32'(abort_seen), 32'(m_aborts));
    if (run != 0) begin
      check_eq({tag, "/prog_sel"}, 32'(program_selection), 32'(m_launch_sel));
    end
  endtask

  task automatic set_raw(input int b, input logic v);
    case (b)
      0: btn_prog_raw = v;
      1: btn_start_raw = v;
      2: btn_cancel_raw = v;
      default: btn_cancel_raw = v;
    endcase
  endtask

  // One clean button press: long stable high, then long stable low.
  task automatic press(input int b);
    int hold;
    hold = $urandom_range(8, 12);
    @(negedge clk);
    set_raw(b, 1'b1);
    repeat (hold) @(negedge clk);
    set_raw(b, 1'b0);
    repeat (12) @(negedge clk);
  endtask

  task automatic glitch(input int b);
    @(negedge clk);
    set_raw(b, 1'b1);
    repeat (2) @(negedge clk);
    set_raw(b, 1'b0);
    repeat (10) @(negedge clk);
  endtask

  // Effect of a press on the panel model (door/soap as they stand now).
  task automatic model_press(input int b);
    m_latch = 0;
    case (m_state)
      M_IDLE: begin
        if (b == 0) begin
          m_sel = (m_sel + 1) % NPROG;
        end else if (b == 1) begin
          if (!door_closed) begin
            m_latch = 1;
          end else if ((m_sel == int'(COLD_WASH) || m_sel == int'(HOT_WASH)) && !soap_present) begin
            m_state = M_WAIT;
          end else begin
            m_state = M_RUN;
            m_starts++;
            m_launch_sel = m_sel;
          end
        end
      end
      M_WAIT: if (b == 2) m_state = M_IDLE;
      M_RUN: begin
        if (b == 2) begin
          m_state = M_IDLE;
          m_aborts++;
        end
      end
      default: m_state = M_IDLE;
    endcase
  endtask

  task automatic do_press(input int b, input string tag);
    press(b);
    model_press(b);
    check_all(tag);
  endtask

  task automatic soap_op();
    @(negedge clk);
    if (m_state == M_WAIT) begin
      soap_present = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("soap_launch_latency", 32'(start_seen), 32'(m_starts + 1));
      m_state = M_RUN;
      m_starts++;
      m_launch_sel = m_sel;
      repeat (3) @(negedge clk);
    end else begin
      soap_present = 1'($urandom_range(0, 1));
      repeat (3) @(negedge clk);
    end
    check_all("soap");
  endtask

  task automatic done_op(input int mode);
    int b;
    @(negedge clk);
    program_done = 1'b1;
    done_seen = 0;
    @(negedge clk);
    program_done = 1'b0;
    if (m_state == M_RUN) begin
      if (mode == 0) begin
        repeat (22) @(negedge clk);
        check_eq("done_hold_cycles", 32'(done_seen), 32'(DHOLD));
      end else begin
        check_eq("done_led_on", 32'(done_led), 32'd1);
        check_eq("done_disp", 32'(disp_value), 32'(exp_disp(0)));
        b = $urandom_range(0, 2);
        press(b);
      end
      m_state = M_IDLE;
      m_latch = 0;
    end else begin
      repeat (3) @(negedge clk);
    end
    check_all("done");
  endtask

  task automatic go_running();
    do_press(2, "go_cancel");
    door_closed = 1'b1;
    soap_present = 1'b1;
    do_press(1, "go_run");
  endtask

  // Cancel press reaching the FSM on the very cycle program_done is high.
  task automatic cancel_with_done();
    go_running();
    done_seen = 0;
    @(negedge clk);
    btn_cancel_raw = 1'b1;
    repeat (6) @(negedge clk);
    program_done = 1'b1;
    @(negedge clk);
    program_done = 1'b0;
    repeat (5) @(negedge clk);
    btn_cancel_raw = 1'b0;
    repeat (12) @(negedge clk);
    m_state = M_IDLE;
    m_aborts++;
    m_latch = 0;
    check_all("cancel_vs_done");
    check_eq("cancel_vs_done/done_led_cycles", 32'(done_seen), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "/start"}, 32'(start), 32'd0);
    check_eq({tag, "/abort"}, 32'(washer_abort), 32'd0);
    check_eq({tag, "/busy"}, 32'(busy), 32'd0);
    check_eq({tag, "/soap_led"}, 32'(soap_warning_led), 32'd0);
    check_eq({tag, "/door_alarm"}, 32'(door_alarm), 32'd0);
    check_eq({tag, "/done_led"}, 32'(done_led), 32'd0);
    check_eq({tag, "/disp"}, 32'(disp_value), 32'd0);
    check_eq({tag, "/prog_sel"}, 32'(program_selection), 32'd0);
  endtask

  task automatic reset_mid_run();
    go_running();
    timer_display = 8'($urandom_range(1, 200));
    door_closed = 1'b0;
    repeat (3) @(negedge clk);
    check_all("pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    m_state = M_IDLE;
    m_sel = 0;
    m_latch = 0;
    @(negedge clk);
    rst_n = 1'b1;
    door_closed = 1'b1;
    repeat (4) @(negedge clk);
    check_all("after_reset");
  endtask

  initial begin
    int op;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Selection stepping, glitch rejection and wrap.
    do_press(0, "prog1");
    do_press(0, "prog2");
    check_eq("sel_is_rinse_dry", 32'(disp_value), 32'(exp_disp(int'(RINSE_DRY))));
    glitch(0);
    check_all("glitch");

    // Launch program 2 (no soap needed) and let DONE time out.
    door_closed = 1'b1;
    soap_present = 1'b0;
    do_press(1, "launch_sel2");
    check_eq("launch_sel2/prog_sel", 32'(program_selection), 32'd2);
    done_op(0);
    do_press(0, "prog3");
    check_eq("sel_is_only_dry", 32'(disp_value), 32'(exp_disp(int'(ONLY_DRY))));
    do_press(0, "prog_wrap");
    check_eq("sel_is_cold_wash", 32'(disp_value), 32'(exp_disp(int'(COLD_WASH))));

    // Soap missing for a wash program, then supplied.
    soap_present = 1'b0;
    do_press(1, "wait_soap");
    soap_op();

    // Display follows the washer timer; cancel aborts.
    timer_display = 8'd45;
    repeat (3) @(negedge clk);
    check_eq("timer45", 32'(disp_value), 32'(exp_disp(45)));
    do_press(2, "cancel_run");

    // Door open at start press latches the alarm; next press clears it.
    door_closed = 1'b0;
    do_press(1, "door_open_start");
    door_closed = 1'b1;
    do_press(0, "alarm_clear");

    cancel_with_done();

    for (int i = 0; i < 70; i++) begin
      op = $urandom_range(0, 7);
      case (op)
        0, 1, 2: do_press(op, "rnd_press");
        3: begin
          glitch($urandom_range(0, 2));
          check_all("rnd_glitch");
        end
        4: begin
          @(negedge clk);
          door_closed = ($urandom_range(0, 3) != 0);
          repeat (2) @(negedge clk);
          check_all("rnd_door");
        end
        5: soap_op();
        6: begin
          @(negedge clk);
          timer_display = 8'($urandom_range(0, 255));
          repeat (3) @(negedge clk);
          check_all("rnd_timer");
        end
        default: done_op($urandom_range(0, 1));
      endcase
    end

    reset_mid_run();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Bound the whole run.
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
